// File: rtl/zlib_bs_pkg.sv
// Shared definitions for the bit-stream packer.
//   bs_state_e  : packer FSM encoding (RUN, FLSH)
//   clog2       : ceiling log2, used to derive widths from parameters
//   ceil_bytes  : number of bytes needed to hold a given number of bits
package zlib_bs_pkg;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_FLSH = 1'b1
    } bs_state_e;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < v) r = i + 1;
        end
        return r;
    endfunction

    // Result is wider than any caller needs; callers truncate to their own width.
    function automatic logic [15:0] ceil_bytes(input logic [15:0] bits);
        return (bits + 16'd7) >> 3;
    endfunction

endpackage

// File: rtl/bs_pack_fifo.sv
// Output FIFO for the bit-stream packer. Synchronous, first-word-fall-through:
// the head entry is presented on rdat_o whenever empty_o is low.
// Ports:
//   clk, rstn        clock, asynchronous active-low reset (empties the FIFO)
//   push_i, wdat_i   write strobe and payload (ignored while full)
//   pop_i            remove the head entry (ignored while empty)
//   rdat_o           head payload, valid only while empty_o is low
//   full_o, empty_o  occupancy flags
module bs_pack_fifo
    import zlib_bs_pkg::*;
#(
    parameter int WD    = 36,
    parameter int DEPTH = 4
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          push_i,
    input  logic [WD-1:0] wdat_i,
    input  logic          pop_i,
    output logic [WD-1:0] rdat_o,
    output logic          full_o,
    output logic          empty_o
);

    localparam int AW = clog2(DEPTH);

    logic [WD-1:0] mem_q [DEPTH];
    logic [AW:0]   wr_ptr_q, wr_ptr_d;
    logic [AW:0]   rd_ptr_q, rd_ptr_d;
    logic          push_ok;
    logic          pop_ok;

    // Pointers carry one extra wrap bit so full and empty can be told apart.
    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

    assign push_ok  = push_i & ~full_o;
    assign pop_ok   = pop_i & ~empty_o;
    assign wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, push_ok};
    assign rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, pop_ok};

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q[AW-1:0]] <= wdat_i;
    end

    assign rdat_o = mem_q[rd_ptr_q[AW-1:0]];

endmodule

// File: rtl/bs_packer.sv
// Bit-stream packer: appends 1..IN_WD LSBs per input beat, LSB-first, into
// OUT_WD-bit words and queues them in an output FIFO. A flush beat closes the
// stream with a zero-padded final word tagged with its byte count.
// Ports:
//   clk, rstn                  clock, asynchronous active-low reset
//   in_vld_i / in_rdy_o        input handshake
//   in_dat_i, in_numb_i        bits to append, count of valid LSBs minus 1
//   in_flush_i                 beat is the last of the stream
//   out_vld_o / out_rdy_i      output handshake (FIFO head)
//   out_dat_o, out_last_o      packed word, final-word tag
//   out_bytes_o                valid bytes in the head word
//
// state   | meaning
// --------+-----------------------------------------------------------
// ST_RUN  | accepting beats; full words are pushed as they fill
// ST_FLSH | flush straddled a word; waiting to push the remainder word
module bs_packer
    import zlib_bs_pkg::*;
#(
    parameter  int IN_WD      = 32,
    parameter  int OUT_WD     = 32,
    parameter  int FIFO_DEPTH = 4,
    localparam int NUMB_WD    = clog2(IN_WD),
    localparam int BYTE_WD    = clog2(OUT_WD / 8) + 1
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic               in_vld_i,
    output logic               in_rdy_o,
    input  logic [IN_WD-1:0]   in_dat_i,
    input  logic [NUMB_WD-1:0] in_numb_i,
    input  logic               in_flush_i,
    output logic               out_vld_o,
    input  logic               out_rdy_i,
    output logic [OUT_WD-1:0]  out_dat_o,
    output logic               out_last_o,
    output logic [BYTE_WD-1:0] out_bytes_o
);

    localparam int ACC_WD = OUT_WD + IN_WD - 1;
    localparam int TOT_WD = clog2(OUT_WD) + 2;
    localparam int PL_WD  = 1 + BYTE_WD + OUT_WD;

    localparam logic [TOT_WD-1:0]  OUT_BITS   = TOT_WD'(OUT_WD);
    localparam logic [BYTE_WD-1:0] FULL_BYTES = BYTE_WD'(OUT_WD / 8);

    bs_state_e          state_q, state_d;
    logic [ACC_WD-1:0]  acc_q, acc_d;
    logic [TOT_WD-1:0]  cnt_q, cnt_d;

    logic               accept;
    logic [TOT_WD-1:0]  n_bits;
    logic [TOT_WD-1:0]  tot;
    logic [IN_WD-1:0]   in_mask;
    logic [ACC_WD-1:0]  acc_app;
    logic [OUT_WD-1:0]  tail_mask;
    logic [15:0]        tot_bytes16;
    logic [15:0]        cnt_bytes16;

    logic               push;
    logic [OUT_WD-1:0]  push_dat;
    logic               push_last;
    logic [BYTE_WD-1:0] push_bytes;

    logic               fifo_full;
    logic               fifo_empty;
    logic [PL_WD-1:0]   head;

    assign in_rdy_o = (state_q == ST_RUN) & ~fifo_full;
    assign accept   = in_vld_i & in_rdy_o;

    assign n_bits  = TOT_WD'(in_numb_i) + TOT_WD'(1);
    assign tot     = cnt_q + n_bits;
    // Shift by n == IN_WD yields zero, so the mask becomes all ones.
    assign in_mask = ~({IN_WD{1'b1}} << n_bits);
    // Bits of acc_q at and above cnt_q are always zero, so OR is an append.
    assign acc_app = acc_q | (ACC_WD'(in_dat_i & in_mask) << cnt_q);

    assign tail_mask   = ~({OUT_WD{1'b1}} << tot);
    assign tot_bytes16 = ceil_bytes(16'(tot));
    assign cnt_bytes16 = ceil_bytes(16'(cnt_q));

    always_comb begin
        state_d    = state_q;
        acc_d      = acc_q;
        cnt_d      = cnt_q;
        push       = 1'b0;
        push_dat   = acc_app[OUT_WD-1:0];
        push_last  = 1'b0;
        push_bytes = FULL_BYTES;
        case (state_q)
            ST_RUN: begin
                if (accept) begin
                    if (tot >= OUT_BITS) begin
                        push  = 1'b1;
                        acc_d = acc_app >> OUT_WD;
                        cnt_d = tot - OUT_BITS;
                        if (in_flush_i) begin
                            if (tot == OUT_BITS) begin
                                push_last = 1'b1;
                                acc_d     = '0;
                                cnt_d     = '0;
                            end else begin
                                state_d = ST_FLSH;
                            end
                        end
                    end else if (in_flush_i) begin
                        push       = 1'b1;
                        push_last  = 1'b1;
                        push_dat   = acc_app[OUT_WD-1:0] & tail_mask;
                        push_bytes = BYTE_WD'(tot_bytes16);
                        acc_d      = '0;
                        cnt_d      = '0;
                    end else begin
                        acc_d = acc_app;
                        cnt_d = tot;
                    end
                end
            end
            ST_FLSH: begin
                if (!fifo_full) begin
                    push       = 1'b1;
                    push_last  = 1'b1;
                    push_dat   = acc_q[OUT_WD-1:0];
                    push_bytes = BYTE_WD'(cnt_bytes16);
                    acc_d      = '0;
                    cnt_d      = '0;
                    state_d    = ST_RUN;
                end
            end
            default: state_d = ST_RUN;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= ST_RUN;
            acc_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
        end
    end

    bs_pack_fifo #(
        .WD    (PL_WD),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rstn    (rstn),
        .push_i  (push),
        .wdat_i  ({push_last, push_bytes, push_dat}),
        .pop_i   (out_rdy_i),
        .rdat_o  (head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    // FIFO storage is not reset; outputs are forced to zero while empty.
    assign out_vld_o   = ~fifo_empty;
    assign out_dat_o   = out_vld_o ? head[OUT_WD-1:0] : '0;
    assign out_bytes_o = out_vld_o ? head[OUT_WD +: BYTE_WD] : '0;
    assign out_last_o  = out_vld_o & head[PL_WD-1];

endmodule

// File: tb/tb_bs_packer.sv
module tb_bs_packer;

    logic        clk;
    logic        rstn;
    logic        in_vld_i;
    logic        in_rdy_o;
    logic [31:0] in_dat_i;
    logic [4:0]  in_numb_i;
    logic        in_flush_i;
    logic        out_vld_o;
    logic        out_rdy_i;
    logic [31:0] out_dat_o;
    logic        out_last_o;
    logic [2:0]  out_bytes_o;

    bs_packer #(
        .IN_WD      (32),
        .OUT_WD     (32),
        .FIFO_DEPTH (4)
    ) dut (
        .clk         (clk),
        .rstn        (rstn),
        .in_vld_i    (in_vld_i),
        .in_rdy_o    (in_rdy_o),
        .in_dat_i    (in_dat_i),
        .in_numb_i   (in_numb_i),
        .in_flush_i  (in_flush_i),
        .out_vld_o   (out_vld_o),
        .out_rdy_i   (out_rdy_i),
        .out_dat_o   (out_dat_o),
        .out_last_o  (out_last_o),
        .out_bytes_o (out_bytes_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] dat;
        logic [4:0]  numb;
        logic        flush;
        int          nexp;
        logic [31:0] w0;
        logic        l0;
        logic [2:0]  b0;
        logic [31:0] w1;
        logic        l1;
        logic [2:0]  b1;
    } beat_t;

    typedef struct packed {
        logic [31:0] dat;
        logic        last;
        logic [2:0]  bytes;
    } exp_t;

    exp_t  sb[$];
    int    n_chk  = 0;
    int    n_fail = 0;
    beat_t tbl[12];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic beat_t mk(input logic [31:0] dat, input logic [4:0] numb, input logic flush,
                                 input int nexp,
                                 input logic [31:0] w0, input logic l0, input logic [2:0] b0,
                                 input logic [31:0] w1, input logic l1, input logic [2:0] b1);
        beat_t b;
        b.dat = dat; b.numb = numb; b.flush = flush; b.nexp = nexp;
        b.w0 = w0; b.l0 = l0; b.b0 = b0;
        b.w1 = w1; b.l1 = l1; b.b1 = b1;
        return b;
    endfunction

    // Entered just after a rising edge; returns just after the accepting edge.
    task automatic drive_beat(input beat_t b);
        logic accepted;
        accepted   = 1'b0;
        in_vld_i   = 1'b1;
        in_dat_i   = b.dat;
        in_numb_i  = b.numb;
        in_flush_i = b.flush;
        for (int i = 0; i < 200 && !accepted; i++) begin
            @(negedge clk);
            accepted = in_rdy_o;
            @(posedge clk);
            #1;
        end
        in_vld_i   = 1'b0;
        in_flush_i = 1'b0;
        if (accepted) begin
            if (b.nexp >= 1) sb.push_back('{dat: b.w0, last: b.l0, bytes: b.b0});
            if (b.nexp >= 2) sb.push_back('{dat: b.w1, last: b.l1, bytes: b.b1});
        end else begin
            n_chk++;
            n_fail++;
            $display("FAIL beat_accept: beat %0h never accepted (in_rdy_o stuck low)", b.dat);
        end
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 100 && sb.size() != 0; i++) @(negedge clk);
        chk("drain_queue_empty", sb.size(), 0);
        @(posedge clk);
        #1;
    endtask

    // Scoreboard consumer: compares every popped head against the queue.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (out_vld_o && out_rdy_i) begin
                if (sb.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL unexpected_word: got %0h with nothing expected", out_dat_o);
                end else begin
                    e = sb.pop_front();
                    chk("word_dat", out_dat_o, e.dat);
                    chk("word_last", out_last_o, e.last);
                    chk("word_bytes", out_bytes_o, e.bytes);
                end
            end
        end
    end

    initial begin
        tbl[0]  = mk(32'hFFFF_FFFD, 5'd2,  1'b0, 0, 0, 0, 0, 0, 0, 0);
        tbl[1]  = mk(32'h0000_0003, 5'd1,  1'b1, 1, 32'h0000_001D, 1, 3'd1, 0, 0, 0);
        tbl[2]  = mk(32'hDEAD_BEEF, 5'd31, 1'b1, 1, 32'hDEAD_BEEF, 1, 3'd4, 0, 0, 0);
        tbl[3]  = mk(32'h0000_0ABC, 5'd11, 1'b0, 0, 0, 0, 0, 0, 0, 0);
        tbl[4]  = mk(32'h0000_0DEF, 5'd11, 1'b0, 0, 0, 0, 0, 0, 0, 0);
        tbl[5]  = mk(32'h0000_0123, 5'd11, 1'b1, 2, 32'h23DE_FABC, 0, 3'd4, 32'h0000_0001, 1, 3'd1);
        tbl[6]  = mk(32'h0001_2345, 5'd19, 1'b1, 1, 32'h0001_2345, 1, 3'd3, 0, 0, 0);
        tbl[7]  = mk(32'h0000_0007, 5'd0,  1'b1, 1, 32'h0000_0001, 1, 3'd1, 0, 0, 0);
        tbl[8]  = mk(32'hCAFE_1234, 5'd15, 1'b0, 0, 0, 0, 0, 0, 0, 0);
        tbl[9]  = mk(32'h5678_BEEF, 5'd23, 1'b0, 1, 32'hBEEF_1234, 0, 3'd4, 0, 0, 0);
        tbl[10] = mk(32'hFFFF_FF9A, 5'd7,  1'b1, 1, 32'h0000_9A78, 1, 3'd2, 0, 0, 0);
        tbl[11] = mk(32'h0000_0055, 5'd6,  1'b1, 1, 32'h0000_0055, 1, 3'd1, 0, 0, 0);

        rstn       = 1'b0;
        in_vld_i   = 1'b0;
        in_dat_i   = '0;
        in_numb_i  = '0;
        in_flush_i = 1'b0;
        out_rdy_i  = 1'b1;
        repeat (3) @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
        chk("rst_out_vld", out_vld_o, 0);
        chk("rst_in_rdy", in_rdy_o, 1);
        chk("rst_out_dat", out_dat_o, 0);
        chk("rst_out_last", out_last_o, 0);
        chk("rst_out_bytes", out_bytes_o, 0);
        @(posedge clk);
        #1;

        // Byte beats with output latency check
        drive_beat(mk(32'h11, 5'd7, 1'b0, 0, 0, 0, 0, 0, 0, 0));
        drive_beat(mk(32'h22, 5'd7, 1'b0, 0, 0, 0, 0, 0, 0, 0));
        drive_beat(mk(32'h33, 5'd7, 1'b0, 0, 0, 0, 0, 0, 0, 0));
        @(negedge clk);
        chk("bytes_no_early_vld", out_vld_o, 0);
        @(posedge clk);
        #1;
        drive_beat(mk(32'h44, 5'd7, 1'b0, 1, 32'h4433_2211, 0, 3'd4, 0, 0, 0));
        @(negedge clk);
        chk("bytes_latency_vld", out_vld_o, 1);
        @(posedge clk);
        #1;
        wait_drain();

        // Table-driven beats
        for (int i = 0; i < 12; i++) drive_beat(tbl[i]);
        wait_drain();

        // Straddle flush: in_rdy_o low for the FLSH cycle
        drive_beat(mk(32'h3FFF_FFFF, 5'd29, 1'b0, 0, 0, 0, 0, 0, 0, 0));
        drive_beat(mk(32'h0000_000A, 5'd3, 1'b1, 2, 32'hBFFF_FFFF, 0, 3'd4, 32'h0000_0002, 1, 3'd1));
        @(negedge clk);
        chk("flsh_in_rdy_low", in_rdy_o, 0);
        chk("flsh_first_head", out_dat_o, 32'hBFFF_FFFF);
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("flsh_in_rdy_back", in_rdy_o, 1);
        chk("flsh_second_head", out_dat_o, 32'h0000_0002);
        @(posedge clk);
        #1;
        wait_drain();

        // Backpressure: four words fill the FIFO, fifth waits
        out_rdy_i = 1'b0;
        for (int k = 1; k <= 4; k++)
            drive_beat(mk(32'(k), 5'd31, 1'b0, 1, 32'(k), 0, 3'd4, 0, 0, 0));
        in_vld_i  = 1'b1;
        in_dat_i  = 32'd5;
        in_numb_i = 5'd31;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("bp_in_rdy_low", in_rdy_o, 0);
            chk("bp_head_vld", out_vld_o, 1);
            chk("bp_head_stable", out_dat_o, 32'd1);
        end
        @(posedge clk);
        #1;
        out_rdy_i = 1'b1;
        drive_beat(mk(32'd5, 5'd31, 1'b0, 1, 32'd5, 0, 3'd4, 0, 0, 0));
        wait_drain();

        // Exact fill flush leaves no trailing word
        drive_beat(tbl[2]);
        repeat (6) @(negedge clk);
        chk("exact_no_trailing_queue", sb.size(), 0);
        chk("exact_no_trailing_vld", out_vld_o, 0);
        @(posedge clk);
        #1;

        // Reset mid-stream discards accumulated bits
        drive_beat(mk(32'h000F_FFFF, 5'd19, 1'b0, 0, 0, 0, 0, 0, 0, 0));
        @(negedge clk);
        rstn = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
        chk("midrst_out_vld", out_vld_o, 0);
        chk("midrst_in_rdy", in_rdy_o, 1);
        @(posedge clk);
        #1;
        drive_beat(mk(32'h0000_005A, 5'd7, 1'b1, 1, 32'h0000_005A, 1, 3'd1, 0, 0, 0));
        wait_drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
